ntt_addr_gen: RTL
=================

NTT_ADDR_GEN -- requirements
Module: ntt_addr_gen

Interface
REQ-001 The block SHALL have parameter LOGN, default 3, meaning log2 of the transform size; legal range 2..10.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port start  input  1  begin a transform; sampled only in IDLE.
REQ-005 The block SHALL have port inverse  input  1  0 = forward (stage size ascending), 1 = inverse (descending); sampled with start.
REQ-006 The block SHALL have port ready  input  1  downstream butterfly accepts the current beat.
REQ-007 The block SHALL have port valid  output  1  addr_a/addr_b/tw_idx/stage hold a beat.
REQ-008 The block SHALL have port addr_a  output  LOGN  upper-leg coefficient address.
REQ-009 The block SHALL have port addr_b  output  LOGN  lower-leg coefficient address.
REQ-010 The block SHALL have port tw_idx  output  LOGN-1  twiddle ROM index.
REQ-011 The block SHALL have port stage  output  4  current stage number, 0..LOGN-1.
REQ-012 The block SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 The block SHALL have port done  output  1  one-cycle pulse at transform end.

Function
REQ-014 The block SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 Transitions SHALL be: IDLE->RUN on start=1; RUN->DONE on handshake of the final beat; DONE->IDLE unconditionally after one cycle.
REQ-016 On IDLE->RUN the block SHALL latch inverse, clear stage counter s and butterfly counter j to 0.
REQ-017 valid SHALL equal (state==RUN), so the first beat appears the cycle after start is sampled.
REQ-018 A handshake SHALL be valid&ready; only a handshake advances j.
REQ-019 When valid=1 and ready=0, all beat outputs SHALL hold stable.
REQ-020 j SHALL range 0..2^(LOGN-1)-1; on handshake with j at max, j SHALL wrap to 0 and s SHALL increment.
REQ-021 The final beat SHALL be s=LOGN-1, j=2^(LOGN-1)-1; total beats = LOGN*2^(LOGN-1).
REQ-022 Effective level e SHALL be s when forward and LOGN-1-s when inverse; h = 2^e.
REQ-023 The block SHALL output k=j mod h, g=j>>e, addr_a=g*2h+k, addr_b=addr_a+h, tw_idx=k<<(LOGN-1-e), stage=s.
REQ-024 No output arithmetic SHALL overflow: addr_b <= 2^LOGN-1 and tw_idx <= 2^(LOGN-1)-1 by construction.
REQ-025 done SHALL be 1 exactly in the DONE cycle; busy SHALL be 1 in RUN and DONE.
REQ-026 start SHALL be ignored in RUN and DONE; inverse changes after start SHALL not affect the transform in progress.
REQ-027 start asserted in the cycle DONE returns to IDLE SHALL be sampled on the following edge (back-to-back transforms allowed with one idle cycle).
REQ-028 When valid=0, addr_a, addr_b, tw_idx and stage SHALL be 0.

Reset
REQ-029 rst_n=0 at a rising edge SHALL force state IDLE, s=0, j=0, latched inverse=0, regardless of state.
REQ-030 During and after reset, outputs SHALL be valid=0, busy=0, done=0, addr_a=0, addr_b=0, tw_idx=0, stage=0.
REQ-031 Reset asserted mid-RUN SHALL abort the transform with no done pulse.

Verification
REQ-032 The bench SHALL cover forward, LOGN=3, ready=1, start at edge 0: beats on cycles 1..12 (a,b,tw) = (0,1,0)(2,3,0)(4,5,0)(6,7,0) (0,2,0)(1,3,2)(4,6,0)(5,7,2) (0,4,0)(1,5,1)(2,6,2)(3,7,3). Required: done=1 on cycle 13 only, busy=0 on cycle 14.
REQ-033 The bench SHALL cover inverse, LOGN=3: first stage = (0,4,0)(1,5,1)(2,6,2)(3,7,3) with stage=0; last stage = (0,1,0)(2,3,0)(4,5,0)(6,7,0) with stage=2.
REQ-034 The bench SHALL cover backpressure: ready=0 for 3 cycles on beat (1,3,2). Required: outputs hold (1,3,2) for 4 cycles; the sequence resumes unchanged; done is delayed by exactly 3 cycles.
REQ-035 The bench SHALL cover start during RUN and inverse toggling mid-transform. Required: no restart, and the sequence is identical to the undisturbed run.
REQ-036 The bench SHALL cover rst_n=0 for one cycle at beat 5 (0,2,0). Required: next cycle valid=0, busy=0; no done pulse; a new start gives first beat (0,1,0).
REQ-037 The bench SHALL cover LOGN=4 forward with random ready. Required: handshaken beat count is 32; every address pair covers all 16 addresses once per stage; final beat (7,15,7).

Source files
------------

// File: rtl/ntt_addr_gen.sv
// ntt_addr_gen -- butterfly address sequencer for an in-place radix-2 NTT.
//
// Walks LOGN stages of 2^(LOGN-1) butterflies each and presents one beat per
// accepted handshake: the two coefficient addresses of the butterfly, the
// twiddle ROM index and the stage number. Forward transforms visit stage
// sizes in ascending order, inverse transforms in descending order.
//
// Ports
//   clk      sole clock, rising edge
//   rst_n    synchronous active-low reset
//   start    begin a transform (sampled only in IDLE)
//   inverse  direction, captured together with start
//   ready    downstream butterfly accepts the current beat
//   valid    addr_a/addr_b/tw_idx/stage carry a beat
//   addr_a   upper-leg coefficient address
//   addr_b   lower-leg coefficient address
//   tw_idx   twiddle ROM index
//   stage    current stage number, 0..LOGN-1
//   busy     high while RUN or DONE
//   done     one-cycle pulse after the final beat is accepted
module ntt_addr_gen #(
  parameter int LOGN = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            inverse,
  input  logic            ready,
  output logic            valid,
  output logic [LOGN-1:0] addr_a,
  output logic [LOGN-1:0] addr_b,
  output logic [LOGN-2:0] tw_idx,
  output logic [3:0]      stage,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0]      LAST_S = 4'(LOGN - 1);
  localparam logic [LOGN-2:0] J_ONE  = (LOGN-1)'(1);
  localparam logic [LOGN-1:0] A_ONE  = LOGN'(1);

  state_t          state;
  logic [3:0]      s;     // stage counter
  logic [LOGN-2:0] j;     // butterfly counter within the stage
  logic            inv;   // direction captured at start

  // Sequencer. The beat outputs are pure decodes of these registers, so they
  // stay stable for as long as ready is held low.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      s     <= '0;
      j     <= '0;
      inv   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            inv   <= inverse;
            s     <= '0;
            j     <= '0;
          end
        end
        RUN: begin
          // valid is high throughout RUN, so ready alone marks a handshake.
          if (ready) begin
            if (&j) begin
              j <= '0;
              if (s == LAST_S) begin
                state <= DONE;
                s     <= '0;
              end else begin
                s <= s + 4'd1;
              end
            end else begin
              j <= j + J_ONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Address decode. e is the butterfly span level: h = 2^e is the distance
  // between the two legs. j splits into a group number g (upper bits) and an
  // offset k inside the group (low e bits); groups are 2h apart.
  logic [3:0]      e;
  logic [LOGN-1:0] h;
  logic [LOGN-1:0] k;
  logic [LOGN-1:0] g;
  logic [LOGN-1:0] a_raw;
  logic [LOGN-1:0] tw_full;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    e       = inv ? (LAST_S - s) : s;
    h       = A_ONE << e;
    k       = {1'b0, j} & (h - A_ONE);
    g       = {1'b0, j} >> e;
    // Bit e of a_raw is always 0, so OR-ing h in is the same as adding it.
    a_raw   = (g << (e + 4'd1)) | k;
    // k < 2^e, so shifting by LOGN-1-e keeps it below 2^(LOGN-1).
    tw_full = k << (LAST_S - e);

    addr_a = '0;
    addr_b = '0;
    tw_idx = '0;
    stage  = '0;
    if (state == RUN) begin
      addr_a = a_raw;
      addr_b = a_raw | h;
      tw_idx = tw_full[LOGN-2:0];
      stage  = s;
    end
  end

  assign valid = (state == RUN);
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);

endmodule
